// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    START     = 2'b01,
    WAIT_DONE = 2'b10
  } arb_state_t;

  localparam int unsigned UART_BYTE_W     = 8;
  localparam int unsigned DEFAULT_NUM_REQ = 4;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner selection: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    int unsigned pos;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    pos    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // Wrap by subtraction so non-power-of-two NUM_REQ needs no divider.
      pos = {{(32-IDX_W){1'b0}}, ptr} + i;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (!valid && req[IDX_W'(pos)]) begin
        valid               = 1'b1;
        onehot[IDX_W'(pos)] = 1'b1;
        idx                 = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter letting NUM_REQ requesters share one uart_tx.
// Optional txDone watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] data,
  output logic [NUM_REQ-1:0]             ack,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           txStart,
  output logic [UART_BYTE_W-1:0]         txData,
  input  logic                           txDone,
  output logic                           busy,
  output logic                           timeout
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t             state;
  arb_state_t             state_next;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       winner;
  logic [NUM_REQ-1:0]     pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   take;
  logic                   frame_end;
  logic                   wd_expire;
  logic [UART_BYTE_W-1:0] req_byte [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_byte[i] = data[i*UART_BYTE_W +: UART_BYTE_W];
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign take      = (state == IDLE) && enable && pick_valid;
  assign frame_end = (state == WAIT_DONE) && (txDone || wd_expire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (take) state_next = START;
      START:     state_next = WAIT_DONE;
      WAIT_DONE: if (frame_end) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      winner <= '0;
      grant  <= '0;
      txData <= '0;
    end else if (take) begin
      winner <= pick_idx;
      grant  <= pick_onehot;
      txData <= req_byte[pick_idx];
    end else if (frame_end) begin
      grant <= '0;
      ptr   <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  // ack and txStart decode straight from the registered state, so the
  // asynchronous reset clears them without waiting for an edge.
  always_comb begin
    ack     = (state == START) ? grant : '0;
    txStart = (state == START);
    busy    = (state != IDLE);
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_q;

  assign wd_expire = (state == WAIT_DONE) && !txDone &&
                     (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt    <= (state == WAIT_DONE) ? wd_cnt + 1'b1 : '0;
      timeout_q <= wd_expire;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign wd_expire          = 1'b0;
  assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        txStart;
  logic [7:0]  txData;
  logic        txDone;
  logic        busy;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .req     (req),
    .data    (data),
    .ack     (ack),
    .grant   (grant),
    .txStart (txStart),
    .txData  (txData),
    .txDone  (txDone),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = '0;
    txDone = 1'b0;
    enable = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input int max_cycles, output int cycles);
    cycles = -1;
    for (int k = 0; k <= max_cycles; k++) begin
      if (txStart === 1'b1) begin
        cycles = k;
        break;
      end
      cyc();
    end
  endtask

  task automatic end_frame();
    txDone = 1'b1;
    cyc();
    txDone = 1'b0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b1;
    req    = 4'b1111;
    txDone = 1'b0;
    data   = 32'h77A53C5A;
    cyc();
    cyc();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
    checks++; if (txStart !== 1'b0) begin errors++; $display("FAIL reset_txStart got %b want 0", txStart); end
    checks++; if (txData !== 8'h00) begin errors++; $display("FAIL reset_txData got %h want 00", txData); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    cyc();
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack got %b want 0100", ack); end
    checks++; if (txStart !== 1'b1) begin errors++; $display("FAIL single_txStart got %b want 1", txStart); end
    checks++; if (txData !== 8'hA5) begin errors++; $display("FAIL single_txData got %h want a5", txData); end
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", grant); end
    req = 4'b0000;
    cyc();
    checks++; if (ack !== 4'b0000 || txStart !== 1'b0) begin errors++; $display("FAIL single_pulse ack %b txStart %b want 0000 0", ack, txStart); end
    checks++; if (grant !== 4'b0100 || txData !== 8'hA5) begin errors++; $display("FAIL single_hold grant %b txData %h want 0100 a5", grant, txData); end
    cyc();
    cyc();
    end_frame();
    checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL single_done busy %b grant %b want 0 0000", busy, grant); end
    req = 4'b1001;
    cyc();
    checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL single_ptr3 got %b want 1000", ack); end
    req = 4'b0000;
    cyc();
    end_frame();
  endtask

  task automatic test_done_ignored();
    do_reset();
    txDone = 1'b1;
    cyc();
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle busy got %b want 0", busy); end
    req = 4'b0001;
    cyc();
    checks++; if (txStart !== 1'b1) begin errors++; $display("FAIL ign_grant txStart got %b want 1", txStart); end
    req = 4'b0000;
    cyc();
    checks++; if (busy !== 1'b1 || txStart !== 1'b0) begin errors++; $display("FAIL ign_start busy %b txStart %b want 1 0", busy, txStart); end
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_wait busy got %b want 0", busy); end
    txDone = 1'b0;
  endtask

  task automatic test_contention();
    int n;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_ack;
    do_reset();
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      exp_ack = 4'b0001 << order[f];
      wait_start(8, n);
      checks++; if (n !== 1) begin errors++; $display("FAIL contention_latency frame %0d got %0d want 1", f, n); end
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL contention_ack frame %0d got %b want %b", f, ack, exp_ack); end
      if (f == 4) req = 4'b0000;
      cyc();
      cyc();
      cyc();
      end_frame();
    end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    data = 32'h77A53C5A;
    req  = 4'b0100;
    cyc();
    req = 4'b0000;
    cyc();
    end_frame();
    req = 4'b0011;
    wait_start(4, n);
    checks++; if (ack !== 4'b0001 || txData !== 8'h5A) begin errors++; $display("FAIL wrap_first ack %b txData %h want 0001 5a", ack, txData); end
    req = 4'b0010;
    cyc();
    end_frame();
    wait_start(4, n);
    checks++; if (ack !== 4'b0010 || txData !== 8'h3C) begin errors++; $display("FAIL wrap_second ack %b txData %h want 0010 3c", ack, txData); end
    req = 4'b0000;
    cyc();
    end_frame();
  endtask

  task automatic test_enable();
    int bad = 0;
    do_reset();
    enable = 1'b0;
    req    = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (ack !== 4'b0000 || txStart !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL enable_block bad cycles got %0d want 0", bad); end
    enable = 1'b1;
    cyc();
    checks++; if (ack !== 4'b0001 || txStart !== 1'b1) begin errors++; $display("FAIL enable_grant ack %b txStart %b want 0001 1", ack, txStart); end
    req    = 4'b0000;
    enable = 1'b0;
    cyc();
    end_frame();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enable_inflight busy got %b want 0", busy); end
    req = 4'b0010;
    cyc();
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enable_regate busy got %b want 0", busy); end
    req    = 4'b0000;
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    req = 4'b0010;
    cyc();
    req = 4'b0000;
    cyc();
    end_frame();
    req = 4'b0110;
    cyc();
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL rstmid_pre ack got %b want 0100", ack); end
    cyc();
    rst_n = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0 || txData !== 8'h00) begin errors++; $display("FAIL rstmid_async grant %b busy %b txData %h want 0000 0 00", grant, busy, txData); end
    checks++; if (ack !== 4'b0000 || txStart !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL rstmid_strobes ack %b txStart %b timeout %b want 0000 0 0", ack, txStart, timeout); end
    cyc();
    cyc();
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rstmid_held ack got %b want 0000", ack); end
    rst_n = 1'b1;
    wait_start(4, n);
    checks++; if (n !== 1 || ack !== 4'b0010) begin errors++; $display("FAIL rstmid_reserve latency %0d ack %b want 1 0010", n, ack); end
    req = 4'b0000;
    cyc();
    end_frame();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0001;
    cyc();
    checks++; if (txStart !== 1'b1) begin errors++; $display("FAIL wd_start txStart got %b want 1", txStart); end
    req = 4'b0000;
    cyc();
`ifdef UART_ARB_TIMEOUT_EN
    begin
      int n = -1;
      for (int k = 1; k <= 40; k++) begin
        cyc();
        if (timeout === 1'b1) begin
          n = k;
          break;
        end
      end
      checks++; if (n != 16) begin errors++; $display("FAIL wd_latency got %0d want 16", n); end
      checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL wd_abort busy %b grant %b want 0 0000", busy, grant); end
      cyc();
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wd_pulse timeout got %b want 0", timeout); end
    end
`else
    begin
      int saw = 0;
      for (int k = 0; k < 40; k++) begin
        cyc();
        if (timeout !== 1'b0) saw++;
      end
      checks++; if (saw != 0) begin errors++; $display("FAIL wd_off timeout cycles got %0d want 0", saw); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wd_off_wait busy got %b want 1", busy); end
      end_frame();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_off_done busy got %b want 0", busy); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_done_ignored();
    test_contention();
    test_wrap();
    test_enable();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one uart_tx; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: txDone watchdog limit in clk cycles; used only with UART_ARB_TIMEOUT_EN.
REQ-003 Port clk  input  1: single clock, the same clock that drives the uart_tx clk input; all logic is rising-edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port enable  input  1: when high, new grants are allowed.
REQ-006 Port req  input  NUM_REQ: per-requester request, level; held until the matching ack.
REQ-007 Port data  input  NUM_REQ*8: byte of requester i on bits [8i+7:8i]; stable while req[i] is high.
REQ-008 Port ack  output  NUM_REQ: one-cycle pulse; the byte of requester i has been taken.
REQ-009 Port grant  output  NUM_REQ: one-hot owner of the transmitter; all zero when idle.
REQ-010 Port txStart  output  1: start strobe to uart_tx.
REQ-011 Port txData  output  8: byte to uart_tx.
REQ-012 Port txDone  input  1: frame-complete indication from uart_tx.
REQ-013 Port busy  output  1: high in every state except IDLE.
REQ-014 Port timeout  output  1: one-cycle pulse on watchdog abort; tied 0 without UART_ARB_TIMEOUT_EN.

Function
REQ-015 The FSM has three states, IDLE, START and WAIT_DONE, registered with the encoding defined in the package.
REQ-016 In IDLE, with enable=1 and req!=0, the winner is the first set req bit at or after the priority pointer, searching upward and wrapping modulo NUM_REQ.
REQ-017 On that edge, the block latches data[winner] into txData, sets grant to the winner's one-hot value, and moves the FSM to START.
REQ-018 In START, ack[winner]=1 and txStart=1 for exactly one cycle; the next state is WAIT_DONE.
REQ-019 Latency from req sampled high in IDLE to ack/txStart is 1 cycle.
REQ-020 txData and grant hold constant from START until the return to IDLE.
REQ-021 In WAIT_DONE, txDone=1 returns the FSM to IDLE on the next edge, clears grant, and sets the priority pointer to (winner+1) mod NUM_REQ.
REQ-022 txDone is ignored in IDLE and in START.
REQ-023 Dropping req[winner] after the grant does not affect the frame already in flight.
REQ-024 enable=0 blocks only new grants; a frame already in flight completes normally.
REQ-025 Several simultaneous req bits: exactly one grant is issued; the losers stay pending with no ack.
REQ-026 Sustained requests from all requesters are served in strict rotation; no requester waits more than NUM_REQ-1 frames.
REQ-027 Back-to-back throughput is one byte per frame plus 2 clk cycles (START, then the IDLE decision).

Reset
REQ-028 rst_n low immediately forces: FSM to IDLE, priority pointer to 0, ack=0, grant=0, txStart=0, txData=8'h00, busy=0, timeout=0.
REQ-029 A reset during START or WAIT_DONE abandons the frame; no ack is issued afterwards for that frame.

Configuration
REQ-030 With macro UART_ARB_TIMEOUT_EN defined, a counter clears on entry to WAIT_DONE and increments each cycle there.
REQ-031 When that counter reaches TIMEOUT_CYCLES-1 without txDone, the FSM returns to IDLE, pulses timeout for 1 cycle, clears grant, and advances the pointer as in REQ-021.
REQ-032 Without UART_ARB_TIMEOUT_EN, no counter exists, timeout is constant 0, and WAIT_DONE waits indefinitely.

Structure
REQ-033 Shared package uart_pkg holds the FSM state typedef, the UART byte width constant (8), and the default NUM_REQ.
REQ-034 Winner selection lives in one sub-module, rr_pick: purely combinational, taking req and pointer and returning a one-hot value plus an index.

Verification
REQ-035 Single request: req=4'b0100, data[23:16]=8'hA5 -> next cycle ack=4'b0100, txStart=1, txData=8'hA5; after txDone, busy=0 and pointer=3.
REQ-036 Contention: req=4'b1111 held, txDone pulsed 3 cycles after each txStart -> ack order 0,1,2,3,0.
REQ-037 Wrap-around: pointer=3, req=4'b0011 -> requester 0 is granted first, then requester 1.
REQ-038 Enable gating: enable=0 with req=4'b0001 for 20 cycles -> no ack or txStart; enable=1 -> ack after 1 cycle.
REQ-039 Reset mid-frame: rst_n low in WAIT_DONE -> all outputs reset immediately; after release with req held, the request is re-served starting from requester 0.
REQ-040 With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, txDone never arrives -> timeout pulses exactly 16 cycles after entry to WAIT_DONE and busy falls.
